hazard_unit: RTL and testbench



---
 rtl/hazard_pkg.sv | 23 ++
 rtl/sat_counter.sv | 20 ++
 rtl/hazard_unit.sv | 99 +++++++++
 tb/tb_hazard_unit.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared pipeline definitions for the ID-stage hazard controller.
// State encoding, register-zero constant and pipeline NOP word.
package hazard_pkg;

    typedef enum logic {
        RUN        = 1'b0,
        LOAD_STALL = 1'b1
    } hz_state_e;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // sll $0,$0,0 -- loaded into IF/ID on flush and ID/EX on bubble
    localparam logic [31:0] NOP = 32'h0000_0000;

    function automatic logic reg_match(
        input logic       uses,
        input logic [4:0] src,
        input logic [4:0] dst
    );
        return uses && (src == dst);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with enable; holds at all-ones.
// Shared by the pipeline performance counters.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         arst_n,
    input  logic         en,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            count <= '0;
        end else if (en && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// ID-stage hazard controller: load-use stalls, branch flush,
// data-memory freeze and a stall-cycle statistics counter.
module hazard_unit
    import hazard_pkg::*;
#(
    parameter int LOAD_STALL_CYCLES = 1,
    parameter int CNT_W             = 32
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic [4:0]       id_reg_rs,
    input  logic [4:0]       id_reg_rt,
    input  logic             id_uses_rs,
    input  logic             id_uses_rt,
    input  logic             exe_mem_read,
    input  logic [4:0]       exe_reg_rd,
    input  logic             exe_branch_taken,
    input  logic             mem_busy,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_exe_bubble,
    output logic             pipe_freeze,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [2:0] INIT_WAIT = 3'(LOAD_STALL_CYCLES - 1);

    hz_state_e  state;
    hz_state_e  state_nx;
    logic [2:0] wait_cnt;
    logic [2:0] wait_nx;
    logic       luh;

    assign luh = exe_mem_read
               && (exe_reg_rd != REG_ZERO)
               && (reg_match(id_uses_rs, id_reg_rs, exe_reg_rd)
                || reg_match(id_uses_rt, id_reg_rt, exe_reg_rd));

    always_comb begin
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        if_id_flush   = 1'b0;
        id_exe_bubble = 1'b0;
        pipe_freeze   = 1'b0;
        state_nx      = state;
        wait_nx       = wait_cnt;
        if (!arst_n) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            if_id_flush   = 1'b1;
            id_exe_bubble = 1'b1;
        end else if (mem_busy) begin
            // everything deferred until memory answers
            pipe_freeze = 1'b1;
            pc_write    = 1'b0;
            if_id_write = 1'b0;
        end else if (exe_branch_taken) begin
            if_id_flush   = 1'b1;
            id_exe_bubble = 1'b1;
            state_nx      = RUN;
            wait_nx       = 3'd0;
        end else if (state == LOAD_STALL) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_exe_bubble = 1'b1;
            wait_nx       = wait_cnt - 3'd1;
            if (wait_cnt <= 3'd1) begin
                state_nx = RUN;
            end
        end else if (luh) begin
            pc_write      = 1'b0;
            if_id_write   = 1'b0;
            id_exe_bubble = 1'b1;
            if (LOAD_STALL_CYCLES > 1) begin
                state_nx = LOAD_STALL;
                wait_nx  = INIT_WAIT;
            end
        end
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            state    <= RUN;
            wait_cnt <= 3'd0;
        end else begin
            state    <= state_nx;
            wait_cnt <= wait_nx;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk    (clk),
        .arst_n (arst_n),
        .en     (~pc_write),
        .count  (stall_cnt)
    );

endmodule

// File: tb/tb_hazard_unit.sv
// Directed bench for hazard_unit: three instances share the
// stimulus (1-cycle, 3-cycle load stall, 4-bit counter).
module tb_hazard_unit;

    logic       clk = 1'b0;
    logic       arst_n;
    logic [4:0] rs, rt, rd;
    logic       uses_rs, uses_rt, mem_read, br, busy;

    logic        pw1, iw1, fl1, bb1, fz1;
    logic [31:0] sc1;
    logic        pw3, iw3, fl3, bb3, fz3;
    logic [31:0] sc3;
    logic        pws, iws, fls, bbs, fzs;
    logic [3:0]  scs;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hazard_unit #(.LOAD_STALL_CYCLES(1), .CNT_W(32)) dut1 (
        .clk(clk), .arst_n(arst_n),
        .id_reg_rs(rs), .id_reg_rt(rt),
        .id_uses_rs(uses_rs), .id_uses_rt(uses_rt),
        .exe_mem_read(mem_read), .exe_reg_rd(rd),
        .exe_branch_taken(br), .mem_busy(busy),
        .pc_write(pw1), .if_id_write(iw1),
        .if_id_flush(fl1), .id_exe_bubble(bb1),
        .pipe_freeze(fz1), .stall_cnt(sc1)
    );

    hazard_unit #(.LOAD_STALL_CYCLES(3), .CNT_W(32)) dut3 (
        .clk(clk), .arst_n(arst_n),
        .id_reg_rs(rs), .id_reg_rt(rt),
        .id_uses_rs(uses_rs), .id_uses_rt(uses_rt),
        .exe_mem_read(mem_read), .exe_reg_rd(rd),
        .exe_branch_taken(br), .mem_busy(busy),
        .pc_write(pw3), .if_id_write(iw3),
        .if_id_flush(fl3), .id_exe_bubble(bb3),
        .pipe_freeze(fz3), .stall_cnt(sc3)
    );

    hazard_unit #(.LOAD_STALL_CYCLES(1), .CNT_W(4)) dut_sat (
        .clk(clk), .arst_n(arst_n),
        .id_reg_rs(rs), .id_reg_rt(rt),
        .id_uses_rs(uses_rs), .id_uses_rt(uses_rt),
        .exe_mem_read(mem_read), .exe_reg_rd(rd),
        .exe_branch_taken(br), .mem_busy(busy),
        .pc_write(pws), .if_id_write(iws),
        .if_id_flush(fls), .id_exe_bubble(bbs),
        .pipe_freeze(fzs), .stall_cnt(scs)
    );

    task automatic idle();
        rs = 5'd0; rt = 5'd0; rd = 5'd0;
        uses_rs = 1'b0; uses_rt = 1'b0;
        mem_read = 1'b0; br = 1'b0; busy = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        arst_n = 1'b0;
        tick();
        arst_n = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        arst_n = 1'b0;
        #3;
        checks++;
        if ({pw1, iw1, fl1, bb1, fz1} !== 5'b00110) begin
            errors++;
            $display("FAIL reset_outs got=%b want=00110",
                     {pw1, iw1, fl1, bb1, fz1});
        end
        checks++;
        if (sc1 !== 32'd0) begin
            errors++;
            $display("FAIL reset_cnt got=%0d want=0", sc1);
        end
        tick();
        arst_n = 1'b1;
        tick();
        checks++;
        if ({pw1, iw1, fl1, bb1, fz1, sc1} !== {5'b11000, 32'd0}) begin
            errors++;
            $display("FAIL reset_release got=%b cnt=%0d want=11000 cnt=0",
                     {pw1, iw1, fl1, bb1, fz1}, sc1);
        end
    endtask

    task automatic test_load_use_rs();
        do_reset();
        mem_read = 1'b1; rd = 5'd5; rs = 5'd5; uses_rs = 1'b1;
        #1;
        checks++;
        if ({pw1, iw1, fl1, bb1} !== 4'b0001) begin
            errors++;
            $display("FAIL luh_rs_stall got=%b want=0001",
                     {pw1, iw1, fl1, bb1});
        end
        tick();
        mem_read = 1'b0;
        #1;
        checks++;
        if ({pw1, bb1, sc1} !== {2'b10, 32'd1}) begin
            errors++;
            $display("FAIL luh_rs_after pw=%b bb=%b cnt=%0d want 1 0 1",
                     pw1, bb1, sc1);
        end
        tick();
        checks++;
        if (sc1 !== 32'd1) begin
            errors++;
            $display("FAIL luh_rs_cnt got=%0d want=1", sc1);
        end
    endtask

    task automatic test_load_zero();
        do_reset();
        mem_read = 1'b1; rd = 5'd0; rs = 5'd0; uses_rs = 1'b1;
        #1;
        checks++;
        if ({pw1, bb1, pw3, bb3} !== 4'b1010) begin
            errors++;
            $display("FAIL zero_reg got=%b want=1010",
                     {pw1, bb1, pw3, bb3});
        end
        tick();
        checks++;
        if ({sc1, sc3} !== 64'd0) begin
            errors++;
            $display("FAIL zero_cnt got=%0d/%0d want=0/0", sc1, sc3);
        end
    endtask

    task automatic test_rt_multi();
        do_reset();
        mem_read = 1'b1; rd = 5'd7; rt = 5'd7; uses_rt = 1'b1;
        rs = 5'd3; uses_rs = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({pw3, iw3, bb3} !== 3'b001) begin
                errors++;
                $display("FAIL rt_stall_%0d got=%b want=001",
                         i, {pw3, iw3, bb3});
            end
            tick();
            mem_read = 1'b0;
        end
        #1;
        checks++;
        if ({pw3, bb3, sc3} !== {2'b10, 32'd3}) begin
            errors++;
            $display("FAIL rt_end pw=%b bb=%b cnt=%0d want 1 0 3",
                     pw3, bb3, sc3);
        end
        mem_read = 1'b1; uses_rt = 1'b0;
        #1;
        checks++;
        if (pw3 !== 1'b1) begin
            errors++;
            $display("FAIL rt_unused got=%b want=1", pw3);
        end
        tick();
        mem_read = 1'b0;
        checks++;
        if (sc3 !== 32'd3) begin
            errors++;
            $display("FAIL rt_unused_cnt got=%0d want=3", sc3);
        end
    endtask

    task automatic test_branch_luh();
        do_reset();
        mem_read = 1'b1; rd = 5'd5; rs = 5'd5; uses_rs = 1'b1;
        br = 1'b1;
        #1;
        checks++;
        if ({pw3, iw3, fl3, bb3, pw1, fl1, bb1} !== 7'b1111111) begin
            errors++;
            $display("FAIL br_luh got=%b want=1111111",
                     {pw3, iw3, fl3, bb3, pw1, fl1, bb1});
        end
        tick();
        br = 1'b0; mem_read = 1'b0;
        #1;
        checks++;
        if ({pw3, fl3, bb3, sc3} !== {3'b100, 32'd0}) begin
            errors++;
            $display("FAIL br_next got=%b cnt=%0d want=100 cnt=0",
                     {pw3, fl3, bb3}, sc3);
        end
        busy = 1'b1; br = 1'b1;
        #1;
        checks++;
        if ({fz1, pw1, iw1, fl1, bb1} !== 5'b10000) begin
            errors++;
            $display("FAIL busy_over_br got=%b want=10000",
                     {fz1, pw1, iw1, fl1, bb1});
        end
        tick();
        idle();
    endtask

    task automatic test_freeze();
        do_reset();
        mem_read = 1'b1; rd = 5'd9; rs = 5'd9; uses_rs = 1'b1;
        tick();
        mem_read = 1'b0; busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if ({fz3, pw3, iw3, fl3, bb3} !== 5'b10000) begin
                errors++;
                $display("FAIL freeze_%0d got=%b want=10000",
                         i, {fz3, pw3, iw3, fl3, bb3});
            end
            tick();
        end
        busy = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++;
            if ({fz3, pw3, bb3} !== 3'b001) begin
                errors++;
                $display("FAIL post_freeze_%0d got=%b want=001",
                         i, {fz3, pw3, bb3});
            end
            tick();
        end
        checks++;
        if ({pw3, sc3} !== {1'b1, 32'd7}) begin
            errors++;
            $display("FAIL freeze_end pw=%b cnt=%0d want 1 7", pw3, sc3);
        end
    endtask

    task automatic test_reset_mid_stall();
        do_reset();
        mem_read = 1'b1; rd = 5'd4; rt = 5'd4; uses_rt = 1'b1;
        tick();
        mem_read = 1'b0;
        #1;
        checks++;
        if ({pw3, sc3} !== {1'b0, 32'd1}) begin
            errors++;
            $display("FAIL mid_stall pw=%b cnt=%0d want 0 1", pw3, sc3);
        end
        arst_n = 1'b0;
        #1;
        checks++;
        if ({pw3, iw3, fl3, bb3, fz3, sc3} !== {5'b00110, 32'd0}) begin
            errors++;
            $display("FAIL async_rst got=%b cnt=%0d want=00110 cnt=0",
                     {pw3, iw3, fl3, bb3, fz3}, sc3);
        end
        tick();
        arst_n = 1'b1;
        #1;
        checks++;
        if ({pw3, bb3, sc3} !== {2'b10, 32'd0}) begin
            errors++;
            $display("FAIL rst_release got=%b cnt=%0d want=10 cnt=0",
                     {pw3, bb3}, sc3);
        end
        tick();
        checks++;
        if (sc3 !== 32'd0) begin
            errors++;
            $display("FAIL rst_no_residue cnt=%0d want=0", sc3);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        mem_read = 1'b1; rd = 5'd2; rs = 5'd2; uses_rs = 1'b1;
        for (int i = 0; i < 14; i++) tick();
        checks++;
        if (scs !== 4'd14) begin
            errors++;
            $display("FAIL sat_ramp got=%0d want=14", scs);
        end
        for (int i = 0; i < 6; i++) tick();
        checks++;
        if (scs !== 4'd15) begin
            errors++;
            $display("FAIL sat_hold got=%0d want=15", scs);
        end
        idle();
    endtask

    initial begin
        idle();
        arst_n = 1'b0;
        test_reset();
        test_load_use_rs();
        test_load_zero();
        test_rt_multi();
        test_branch_luh();
        test_freeze();
        test_reset_mid_stall();
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
